// File: rtl/sort_collector_if.sv
// Handshake/bus bundle between the serial sorter, the sort collector and its consumer.
// The slave modport is the collector's view; the master modport drives the collector.
interface sort_collector_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_serial_i;
  logic             data_valid_i;
  logic [WIDTH-1:0] rd_data_o;
  logic             rd_valid_o;
  logic             rd_ready_i;
  logic             rd_last_o;
  logic [CW-1:0]    count_o;
  logic [WIDTH-1:0] min_o;
  logic [WIDTH-1:0] max_o;
  logic             order_err_o;
  logic             len_err_o;
  logic             overflow_o;
  logic             batch_done_o;

  modport slave (
    input  data_serial_i, data_valid_i, rd_ready_i,
    output rd_data_o, rd_valid_o, rd_last_o, count_o, min_o, max_o,
           order_err_o, len_err_o, overflow_o, batch_done_o
  );

  modport master (
    output data_serial_i, data_valid_i, rd_ready_i,
    input  rd_data_o, rd_valid_o, rd_last_o, count_o, min_o, max_o,
           order_err_o, len_err_o, overflow_o, batch_done_o
  );
endinterface

// File: rtl/sort_collector.sv
// Captures one sorted serial batch into a register buffer, checks signed ordering and
// batch length, tracks signed min/max, then drains the batch over valid/ready.
module sort_collector #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  sort_collector_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_buf [DEPTH];
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_min;
  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_prev;
  logic             r_order_err;
  logic             r_len_err;
  logic             r_overflow;
  logic             r_batch_done;

  logic             w_cap_first;
  logic             w_cap_more;
  logic             w_xfer;
  logic             w_last;
  logic [CW-1:0]    w_count_inc;
  logic [WIDTH-1:0] w_din;

  assign w_din       = bus.data_serial_i;
  assign w_cap_first = (r_state == IDLE) && bus.data_valid_i;
  assign w_cap_more  = (r_state == CAPTURE) && bus.data_valid_i;
  assign w_count_inc = r_count + CW'(1);
  assign w_last      = (r_state == DRAIN) && (r_rd_ptr == r_count - CW'(1));
  assign w_xfer      = (r_state == DRAIN) && bus.rd_ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.data_valid_i) w_next = CAPTURE;
      CAPTURE: if (!bus.data_valid_i || (w_count_inc == CW'(DEPTH))) w_next = DRAIN;
      DRAIN:   if (w_xfer && w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Batch statistics only change while capturing; they hold through DRAIN and IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_min        <= '0;
      r_max        <= '0;
      r_prev       <= '0;
      r_order_err  <= 1'b0;
      r_len_err    <= 1'b0;
      r_overflow   <= 1'b0;
      r_batch_done <= 1'b0;
    end else begin
      r_overflow   <= (r_state == DRAIN) && bus.data_valid_i;
      r_batch_done <= w_xfer && w_last;
      if (w_cap_first) begin
        r_count     <= CW'(1);
        r_min       <= w_din;
        r_max       <= w_din;
        r_prev      <= w_din;
        r_order_err <= 1'b0;
        r_len_err   <= 1'b0;
      end else if (w_cap_more) begin
        r_count <= w_count_inc;
        if ($signed(w_din) < $signed(r_min))  r_min <= w_din;
        if ($signed(w_din) > $signed(r_max))  r_max <= w_din;
        if ($signed(w_din) < $signed(r_prev)) r_order_err <= 1'b1;
        r_prev <= w_din;
      end else if (r_state == CAPTURE) begin
        r_len_err <= 1'b1;
      end
      if (w_xfer) r_rd_ptr <= w_last ? '0 : r_rd_ptr + CW'(1);
    end
  end

  // Buffer contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (w_cap_first)     r_buf[0] <= w_din;
    else if (w_cap_more) r_buf[r_count[AW-1:0]] <= w_din;
  end

  assign bus.rd_data_o    = r_buf[r_rd_ptr[AW-1:0]];
  assign bus.rd_valid_o   = (r_state == DRAIN);
  assign bus.rd_last_o    = w_last;
  assign bus.count_o      = r_count;
  assign bus.min_o        = r_min;
  assign bus.max_o        = r_max;
  assign bus.order_err_o  = r_order_err;
  assign bus.len_err_o    = r_len_err;
  assign bus.overflow_o   = r_overflow;
  assign bus.batch_done_o = r_batch_done;
endmodule

// File: doc/sort_collector.md
# sort_collector

Downstream stage of the serial bubble sorter. Captures the sorted serial stream presented while the sorter's valid flag is high into a DEPTH-word register buffer. Checks that the batch is in non-decreasing signed order and tracks min/max. Drains the batch to the consumer through a valid/ready handshake, then re-arms for the next batch.

## Interface
- WIDTH, 32, word width; words are two's-complement signed.
- DEPTH, 8, words per sorted batch; must be ≥2.
- CW, $clog2(DEPTH+1), count width (localparam).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_serial_i  in  WIDTH  sorted word from the sorter.
- data_valid_i  in  1  sorter output valid; one word per high cycle.
- rd_data_o  out  WIDTH  buffer word at the read pointer.
- rd_valid_o  out  1  rd_data_o is valid.
- rd_ready_i  in  1  consumer accepts the word this cycle.
- rd_last_o  out  1  current word is the last of the batch.
- count_o  out  CW  words captured in the current batch.
- min_o / max_o  out  WIDTH  signed min/max of the current batch.
- order_err_o  out  1  sticky: some word < its predecessor (signed).
- len_err_o  out  1  sticky: batch ended with fewer than DEPTH words.
- overflow_o  out  1  one-cycle pulse: input word dropped.
- batch_done_o  out  1  one-cycle pulse: last word accepted.

## Operation
- FSM states are IDLE, CAPTURE and DRAIN; reset state is IDLE.
- IDLE:
  - On data_valid_i=1, write the word to buf[0] and set count=1, min=max=prev=word.
  - Clear order_err and len_err, then go to CAPTURE.
  - If DEPTH words are captured without a drop (not possible in IDLE since DEPTH≥2), the DRAIN rule below applies.
- CAPTURE:
  - On each data_valid_i=1 cycle, write the word to buf[count] and increment count.
  - Update min/max with signed compare.
  - If word < prev (signed), set order_err; then prev←word.
  - The word that makes count=DEPTH moves the FSM to DRAIN.
  - If data_valid_i=0 while count<DEPTH, set len_err and go to DRAIN with the words held so far.
- DRAIN:
  - rd_valid_o=1 and rd_data_o=buf[rd_ptr]; rd_ptr starts at 0.
  - rd_last_o=1 when rd_ptr==count-1.
  - A transfer occurs on rd_valid_o & rd_ready_i, and rd_ptr increments.
  - A transfer with rd_last_o set pulses batch_done_o, clears rd_ptr and returns to IDLE.
- Any data_valid_i=1 cycle in DRAIN drops the word and pulses overflow_o; buffer, count and flags are unchanged.
- count_o, min_o, max_o, order_err_o and len_err_o hold their values through DRAIN and IDLE until the first word of the next batch.
- Signed compares use the full WIDTH; no truncation.

## Timing
- Reset (rst=0, asynchronous):
  - State→IDLE; rd_ptr=0; count_o=0; min_o=max_o=0.
  - rd_valid_o, rd_last_o, order_err_o, len_err_o, overflow_o and batch_done_o all 0.
  - rd_data_o=buf[0]; buffer contents are don't-care.
  - Deassertion takes effect on the next rising edge.
  - Reset mid-batch discards the batch; there is no partial output.
- Capture: one word per cycle, registered on the edge where data_valid_i=1.
- Full-batch latency: rd_valid_o rises in the cycle after the DEPTH-th word is sampled.
- Short-batch latency: rd_valid_o rises in the cycle after the first data_valid_i=0 cycle is sampled in CAPTURE.
- rd_data_o and rd_last_o are decoded from registered state and rd_ptr, with no combinational path from rd_ready_i.
- rd_valid_o, once high, stays high and rd_data_o stays stable until the transfer completes.
- Throughput: one word per cycle in DRAIN with rd_ready_i held 1.
- Next batch: the first word can be accepted in the cycle after batch_done_o.
- overflow_o and batch_done_o are registered single-cycle pulses, asserted in the cycle after the triggering edge.

## Test plan
- Full ascending batch, DEPTH=8:
  - Stimulus: −5, −1, 0, 2, 3, 7, 100, 2147483647 on 8 consecutive valid cycles; rd_ready_i=1.
  - Required: same 8 words out on consecutive cycles starting 1 cycle after the 8th input; rd_last_o only on 2147483647; min_o=−5, max_o=2147483647, count_o=8; no error flags; batch_done_o pulses once.
- Backpressure:
  - Stimulus: same batch with rd_ready_i toggled 1,0,0,1,…
  - Required: each word held stable while not ready; no loss or duplication; exactly 8 transfers.
- Order error:
  - Stimulus: 1, 2, 9, 4, 5, 6, 7, 8.
  - Required: order_err_o=1 from the cycle after 4 is sampled, held through DRAIN; min_o=1, max_o=9; cleared on the next batch's first word.
- Short batch:
  - Stimulus: data_valid_i drops after 5 words (10, 20, 30, 40, 50).
  - Required: len_err_o=1, count_o=5; 5 words drained; rd_last_o on 50.
- Overflow:
  - Stimulus: data_valid_i=1 for 2 cycles during DRAIN with rd_ready_i=0.
  - Required: two overflow_o pulses; drained data unchanged.
- Reset mid-CAPTURE:
  - Stimulus: rst=0 after 3 words, then a fresh 8-word batch.
  - Required: all outputs at reset values immediately; the new batch drains correctly with no stale words.
